pipe_mux: RTL

Parametrised, registered N-to-1 datapath selector with a valid/ready handshake. It is the pipelined successor of the datapath's 4-input 32-bit select muxes. It is used wherever a selected operand or next-PC value must cross a pipeline boundary with stall and flush support, such as operand select into the EX stage or PC source select into IF. It produces one output register stage, preserves order and never drops or duplicates a beat, except on flush.

---
 rtl/pipe_mux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_mux.sv
// pipe_mux: registered N-to-1 selector with a valid/ready handshake.
// Each accepted beat is captured as {data, sel, err} and presented one cycle later.
// Selects past the last channel yield zero data with err set.
// Optional build macro PIPE_MUX_SKID_EN adds a one-entry skid register so that
// in_ready is a flop with no combinational path from out_ready.
module pipe_mux #(
  parameter int unsigned  WIDTH  = 32,
  parameter int unsigned  NUM_IN = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;

  // Decode the incoming beat; an unmatched select yields zero data with err set.
  always_comb begin
    beat_data = '0;
    beat_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        beat_data = in_data[k*WIDTH +: WIDTH];
        beat_err  = 1'b0;
      end
    end
  end

`ifdef PIPE_MUX_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;

  // Output stage refills from skid first (older beat), else from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // in_ready_q is low whenever skid is full, so no accept can collide here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sel_d    = skid_sel_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = beat_data;
        out_sel_d   = sel;
        out_err_d   = beat_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = beat_data;
      skid_sel_d   = sel;
      skid_err_d   = beat_err;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid entry and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output stage: load on accept, drain on output transfer, clear on flush.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_sel_d   = sel;
      out_err_d   = beat_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;

endmodule
